// File: rtl/exec_pkg.sv
// Shared constants, opcode map and state/mode encodings for the execute stage.
package exec_pkg;

   localparam int WIDTH      = 32;
   localparam int AW         = 5;
   localparam int OP_W       = 4;
   localparam int ITER_STEPS = 32;

   localparam logic [5:0] LAST_STEP = 6'(ITER_STEPS - 1);

   localparam logic [OP_W-1:0] OP_ADD   = 4'd0;
   localparam logic [OP_W-1:0] OP_SUB   = 4'd1;
   localparam logic [OP_W-1:0] OP_AND   = 4'd2;
   localparam logic [OP_W-1:0] OP_OR    = 4'd3;
   localparam logic [OP_W-1:0] OP_XOR   = 4'd4;
   localparam logic [OP_W-1:0] OP_NOR   = 4'd5;
   localparam logic [OP_W-1:0] OP_SLT   = 4'd6;
   localparam logic [OP_W-1:0] OP_SLL   = 4'd7;
   localparam logic [OP_W-1:0] OP_SRL   = 4'd8;
   localparam logic [OP_W-1:0] OP_SRA   = 4'd9;
   localparam logic [OP_W-1:0] OP_MULLO = 4'd10;
   localparam logic [OP_W-1:0] OP_DIVU  = 4'd11;
   localparam logic [OP_W-1:0] OP_REMU  = 4'd12;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_ITER = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      MD_MUL  = 2'd0,
      MD_DIVU = 2'd1,
      MD_REMU = 2'd2
   } md_mode_t;

   function automatic logic is_iter_op(input logic [OP_W-1:0] op);
      return (op == OP_MULLO) || (op == OP_DIVU) || (op == OP_REMU);
   endfunction

   function automatic md_mode_t op_to_mode(input logic [OP_W-1:0] op);
      md_mode_t m;
      case (op)
         OP_DIVU: m = MD_DIVU;
         OP_REMU: m = MD_REMU;
         default: m = MD_MUL;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/iter_muldiv.sv
// 32-step iterative unit: shift-add multiply (low word) and restoring unsigned divide.
// acc/shf/opb registers are shared: MUL uses product/multiplicand/multiplier, DIV uses remainder/quotient/divisor.
module iter_muldiv
   import exec_pkg::*;
#(
   parameter int WIDTH = exec_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  md_mode_t         mode_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o
);

   logic             busy_q;
   logic [5:0]       cnt_q;
   md_mode_t         mode_q;
   logic [WIDTH-1:0] acc_q, shf_q, opb_q;
   logic [WIDTH-1:0] acc_d, shf_d, opb_d;
   logic [WIDTH:0]   rem_sh_s, diff_s;
   logic             last_s;

   assign last_s = busy_q && (cnt_q == LAST_STEP);

   // One multiply or divide step; a divisor of zero naturally yields all-ones quotient and remainder = dividend.
   always_comb begin
      rem_sh_s = {acc_q, shf_q[WIDTH-1]};
      diff_s   = rem_sh_s - {1'b0, opb_q};
      acc_d    = acc_q;
      shf_d    = shf_q;
      opb_d    = opb_q;
      if (mode_q == MD_MUL) begin
         if (opb_q[0]) begin
            acc_d = acc_q + shf_q;
         end else begin
            acc_d = acc_q;
         end
         shf_d = {shf_q[WIDTH-2:0], 1'b0};
         opb_d = {1'b0, opb_q[WIDTH-1:1]};
      end else begin
         if (!diff_s[WIDTH]) begin
            acc_d = diff_s[WIDTH-1:0];
            shf_d = {shf_q[WIDTH-2:0], 1'b1};
         end else begin
            acc_d = rem_sh_s[WIDTH-1:0];
            shf_d = {shf_q[WIDTH-2:0], 1'b0};
         end
         opb_d = opb_q;
      end
   end

   // Result taken from the step in flight so the final step lands in the writeback registers directly.
   always_comb begin
      case (mode_q)
         MD_MUL:  result_o = acc_d;
         MD_DIVU: result_o = shf_d;
         MD_REMU: result_o = acc_d;
         default: result_o = '0;
      endcase
   end

   // Operand latch, step counter and shared datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         cnt_q  <= 6'd0;
         mode_q <= MD_MUL;
         acc_q  <= '0;
         shf_q  <= '0;
         opb_q  <= '0;
      end else if (start_i && !busy_q) begin
         busy_q <= 1'b1;
         cnt_q  <= 6'd0;
         mode_q <= mode_i;
         acc_q  <= '0;
         shf_q  <= a_i;
         opb_q  <= b_i;
      end else if (busy_q) begin
         acc_q  <= acc_d;
         shf_q  <= shf_d;
         opb_q  <= opb_d;
         cnt_q  <= last_s ? 6'd0 : cnt_q + 6'd1;
         busy_q <= !last_s;
      end
   end

   assign busy_o = busy_q;
   assign done_o = last_s;

endmodule

// File: rtl/exec_unit.sv
// Execute stage feeding register-bank writeback: single-cycle ALU plus an iterative mul/div path.
module exec_unit
   import exec_pkg::*;
#(
   parameter int WIDTH = exec_pkg::WIDTH,
   parameter int AW    = exec_pkg::AW
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [OP_W-1:0]  op_i,
   input  logic [WIDTH-1:0] opa_i,
   input  logic [WIDTH-1:0] opb_i,
   input  logic [AW-1:0]    dst_i,
   output logic             wb_valid_o,
   output logic [WIDTH-1:0] wb_data_o,
   output logic [AW-1:0]    wb_addr_o,
   output logic             zero_o,
   output logic             ovf_o
);

   localparam int SH_W = $clog2(WIDTH);

   state_t           state_q;
   logic             in_ready_q;
   logic             wb_valid_q;
   logic [WIDTH-1:0] wb_data_q;
   logic [AW-1:0]    wb_addr_q;
   logic             zero_q;
   logic             ovf_q;
   logic [AW-1:0]    dst_q;

   logic             accept_s;
   logic             iter_op_s;
   logic             md_start_s;
   logic             md_busy_s;
   logic             md_done_s;
   logic [WIDTH-1:0] md_result_s;
   logic [WIDTH-1:0] sum_s, dif_s, alu_res_s;
   logic             alu_ovf_s;
   logic [SH_W-1:0]  shamt_s;

   assign accept_s   = in_valid_i && in_ready_q;
   assign iter_op_s  = is_iter_op(op_i);
   assign md_start_s = accept_s && iter_op_s && !md_busy_s;
   assign shamt_s    = opb_i[SH_W-1:0];
   assign sum_s      = opa_i + opb_i;
   assign dif_s      = opa_i - opb_i;

   // Single-cycle ALU; undefined opcodes produce zero and still write back.
   always_comb begin
      alu_res_s = '0;
      alu_ovf_s = 1'b0;
      case (op_i)
         OP_ADD: begin
            alu_res_s = sum_s;
            alu_ovf_s = (opa_i[WIDTH-1] == opb_i[WIDTH-1]) && (sum_s[WIDTH-1] != opa_i[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res_s = dif_s;
            alu_ovf_s = (opa_i[WIDTH-1] != opb_i[WIDTH-1]) && (dif_s[WIDTH-1] != opa_i[WIDTH-1]);
         end
         OP_AND:  alu_res_s = opa_i & opb_i;
         OP_OR:   alu_res_s = opa_i | opb_i;
         OP_XOR:  alu_res_s = opa_i ^ opb_i;
         OP_NOR:  alu_res_s = ~(opa_i | opb_i);
         OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(opa_i) < $signed(opb_i))};
         OP_SLL:  alu_res_s = opa_i << shamt_s;
         OP_SRL:  alu_res_s = opa_i >> shamt_s;
         OP_SRA:  alu_res_s = $unsigned($signed(opa_i) >>> shamt_s);
         default: alu_res_s = '0;
      endcase
   end

   iter_muldiv #(
      .WIDTH (WIDTH)
   ) u_iter_muldiv (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (md_start_s),
      .mode_i   (op_to_mode(op_i)),
      .a_i      (opa_i),
      .b_i      (opb_i),
      .busy_o   (md_busy_s),
      .done_o   (md_done_s),
      .result_o (md_result_s)
   );

   // Control FSM and writeback registers; in_ready reopens in the same cycle the iterative strobe fires.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         in_ready_q <= 1'b1;
         wb_valid_q <= 1'b0;
         wb_data_q  <= '0;
         wb_addr_q  <= '0;
         zero_q     <= 1'b0;
         ovf_q      <= 1'b0;
         dst_q      <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept_s && iter_op_s) begin
                  state_q    <= ST_ITER;
                  in_ready_q <= 1'b0;
                  dst_q      <= dst_i;
                  wb_valid_q <= 1'b0;
               end else if (accept_s) begin
                  wb_valid_q <= 1'b1;
                  wb_data_q  <= alu_res_s;
                  wb_addr_q  <= dst_i;
                  zero_q     <= (alu_res_s == '0);
                  ovf_q      <= alu_ovf_s;
               end else begin
                  wb_valid_q <= 1'b0;
               end
            end
            ST_ITER: begin
               if (md_done_s) begin
                  state_q    <= ST_IDLE;
                  in_ready_q <= 1'b1;
                  wb_valid_q <= 1'b1;
                  wb_data_q  <= md_result_s;
                  wb_addr_q  <= dst_q;
                  zero_q     <= (md_result_s == '0);
                  ovf_q      <= 1'b0;
               end else begin
                  wb_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               in_ready_q <= 1'b1;
               wb_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready_o = in_ready_q;
   assign wb_valid_o = wb_valid_q;
   assign wb_data_o  = wb_data_q;
   assign wb_addr_o  = wb_addr_q;
   assign zero_o     = zero_q;
   assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: ALU ops, flags, iterative mul/div latency and reset abort.
module tb_exec_unit;
   import exec_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  op;
   logic [31:0] opa;
   logic [31:0] opb;
   logic [4:0]  dst;
   logic        wb_valid;
   logic [31:0] wb_data;
   logic [4:0]  wb_addr;
   logic        zero;
   logic        ovf;

   int n_cmp;
   int n_bad;

   exec_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .op_i       (op),
      .opa_i      (opa),
      .opb_i      (opb),
      .dst_i      (dst),
      .wb_valid_o (wb_valid),
      .wb_data_o  (wb_data),
      .wb_addr_o  (wb_addr),
      .zero_o     (zero),
      .ovf_o      (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic put(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
      in_valid = 1'b1;
      op       = o;
      opa      = a;
      opb      = b;
      dst      = d;
   endtask

   // Issue at a negedge, then look at the strobe one cycle later.
   task automatic single(input string tag, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, input logic [31:0] exp, input logic exp_z, input logic exp_v);
      put(o, a, b, d);
      @(negedge clk);
      in_valid = 1'b0;
      check_eq({tag, ".valid"}, {31'd0, wb_valid}, 32'd1);
      check_eq({tag, ".data"},  wb_data, exp);
      check_eq({tag, ".addr"},  {27'd0, wb_addr}, {27'd0, d});
      check_eq({tag, ".zero"},  {31'd0, zero}, {31'd0, exp_z});
      check_eq({tag, ".ovf"},   {31'd0, ovf}, {31'd0, exp_v});
   endtask

   task automatic run_iter(input string tag, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] d, input logic [31:0] exp, input bit follow_add);
      int lat;
      int busy_cnt;
      logic [31:0] got_data;
      logic [4:0]  got_addr;
      logic        got_ready;
      logic        got_ovf;
      lat       = 0;
      busy_cnt  = 0;
      got_data  = 32'd0;
      got_addr  = 5'd0;
      got_ready = 1'b0;
      got_ovf   = 1'b0;
      put(o, a, b, d);
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (!in_ready) busy_cnt++;
         if (wb_valid) begin
            lat       = c;
            got_data  = wb_data;
            got_addr  = wb_addr;
            got_ready = in_ready;
            got_ovf   = ovf;
            break;
         end
         if (c % 4 == 2) put(OP_ADD, 32'd1, 32'd1, 5'd9);
         else in_valid = 1'b0;
      end
      in_valid = 1'b0;
      check_eq({tag, ".latency"}, lat, 32'd33);
      check_eq({tag, ".busy"},    busy_cnt, 32'd32);
      check_eq({tag, ".data"},    got_data, exp);
      check_eq({tag, ".addr"},    {27'd0, got_addr}, {27'd0, d});
      check_eq({tag, ".ready"},   {31'd0, got_ready}, 32'd1);
      check_eq({tag, ".ovf"},     {31'd0, got_ovf}, 32'd0);
      if (follow_add) begin
         put(OP_ADD, 32'd7, 32'd8, 5'd11);
         @(negedge clk);
         in_valid = 1'b0;
         check_eq({tag, ".next.valid"}, {31'd0, wb_valid}, 32'd1);
         check_eq({tag, ".next.data"},  wb_data, 32'd15);
         check_eq({tag, ".next.addr"},  {27'd0, wb_addr}, 32'd11);
      end else begin
         @(negedge clk);
         check_eq({tag, ".pulse"}, {31'd0, wb_valid}, 32'd0);
      end
   endtask

   initial begin
      int strobes;
      n_cmp    = 0;
      n_bad    = 0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      op       = 4'd0;
      opa      = 32'd0;
      opb      = 32'd0;
      dst      = 5'd0;
      repeat (2) @(negedge clk);
      check_eq("rst.valid", {31'd0, wb_valid}, 32'd0);
      check_eq("rst.data",  wb_data, 32'd0);
      check_eq("rst.addr",  {27'd0, wb_addr}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("rst.ready", {31'd0, in_ready}, 32'd1);

      // back-to-back single-cycle ops give back-to-back strobes
      single("add", OP_ADD, 32'd110, 32'd25, 5'd3, 32'd135, 1'b0, 1'b0);
      single("sub", OP_SUB, 32'd110, 32'd25, 5'd4, 32'd85, 1'b0, 1'b0);
      @(negedge clk);
      check_eq("hold.valid", {31'd0, wb_valid}, 32'd0);
      check_eq("hold.data",  wb_data, 32'd85);

      single("add_ovf",  OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd5, 32'h8000_0000, 1'b0, 1'b1);
      single("sub_zero", OP_SUB, 32'd5, 32'd5, 5'd6, 32'd0, 1'b1, 1'b0);
      single("sub_ovf",  OP_SUB, 32'h8000_0000, 32'd1, 5'd6, 32'h7FFF_FFFF, 1'b0, 1'b1);
      single("sra",      OP_SRA, 32'h8000_0000, 32'd31, 5'd7, 32'hFFFF_FFFF, 1'b0, 1'b0);
      single("srl",      OP_SRL, 32'h8000_0000, 32'd31, 5'd7, 32'h0000_0001, 1'b0, 1'b0);
      single("sll",      OP_SLL, 32'd1, 32'h21, 5'd8, 32'd2, 1'b0, 1'b0);
      single("slt",      OP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd9, 32'd1, 1'b0, 1'b0);
      single("slt_no",   OP_SLT, 32'd1, 32'hFFFF_FFFF, 5'd9, 32'd0, 1'b1, 1'b0);
      single("xor",      OP_XOR, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd10, 32'hFF00_EDCB, 1'b0, 1'b0);
      single("nor",      OP_NOR, 32'h0000_00F0, 32'h0000_000F, 5'd10, 32'hFFFF_FF00, 1'b0, 1'b0);
      single("and",      OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd12, 32'h00F0_1234, 1'b0, 1'b0);
      single("op14",     4'd14, 32'd5, 32'd6, 5'd13, 32'd0, 1'b1, 1'b0);

      run_iter("mul",   OP_MULLO, 32'd752, 32'd720, 5'd14, 32'd541440, 1'b0);
      run_iter("divu",  OP_DIVU, 32'd1080, 32'd7, 5'd15, 32'd154, 1'b0);
      run_iter("remu",  OP_REMU, 32'd1080, 32'd7, 5'd16, 32'd2, 1'b0);
      run_iter("div0",  OP_DIVU, 32'd45000, 32'd0, 5'd17, 32'hFFFF_FFFF, 1'b1);
      run_iter("rem0",  OP_REMU, 32'd45000, 32'd0, 5'd18, 32'd45000, 1'b1);
      run_iter("mulbig", OP_MULLO, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd19, 32'd1, 1'b0);

      // reset during step 10 of a multiply aborts it
      put(OP_MULLO, 32'd752, 32'd720, 5'd20);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check_eq("abort.data", wb_data, 32'd0);
      check_eq("abort.addr", {27'd0, wb_addr}, 32'd0);
      check_eq("abort.zero", {31'd0, zero}, 32'd0);
      check_eq("abort.ovf",  {31'd0, ovf}, 32'd0);
      rst_n = 1'b1;
      strobes = 0;
      @(negedge clk);
      check_eq("abort.ready", {31'd0, in_ready}, 32'd1);
      for (int c = 0; c < 40; c++) begin
         if (wb_valid) strobes++;
         @(negedge clk);
      end
      check_eq("abort.strobes", strobes, 32'd0);
      single("post_rst", OP_OR, 32'h0000_1200, 32'h0000_0034, 5'd21, 32'h0000_1234, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
